ssd_scan_driver: RTL and testbench

//  Display end of the core's debug interface. Captures an unsigned binary value from the

---
 rtl/ssd_scan_driver.sv | 134 +++++++++++++
 tb/tb_ssd_scan_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Debug display driver: captures a binary value, converts it to four BCD digits with a
// sequential double-dabble engine, and scans the digits onto a common-anode 4-digit display.
module ssd_scan_driver #(
    parameter int IN_WIDTH    = 13,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                update,
    output logic                busy,
    output logic [3:0]          anode,
    output logic [6:0]          led_out
);

    // state | meaning
    // IDLE  | waiting for update; digit regs hold the last result
    // CONV  | shift-add-3 running, one input bit per cycle
    // DONE  | scratch BCD copied to the digit regs, busy drops
    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [15:0]         bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [15:0]         dig_q, dig_d;
    logic [RW-1:0]       ref_q;
    logic [1:0]          idx_q;
    logic [3:0]          anode_q;
    logic [6:0]          led_q;
    logic [15:0]         dig_upper;
    logic                blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE: begin
                if (update && !busy_q) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = CW'(IN_WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = {bcd_adj[14:0], bin_q[IN_WIDTH-1]};
                bin_d = {bin_q[IN_WIDTH-2:0], 1'b0};
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                dig_d   = bcd_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        dig_upper = dig_q >> {idx_q, 2'b00};
        blank     = BLANK_LZ && (idx_q != 2'd0) && (dig_upper == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dig_q   <= '0;
            ref_q   <= '0;
            idx_q   <= 2'd0;
            anode_q <= 4'b1111;
            led_q   <= 7'b1111111;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dig_q   <= dig_d;
            if (ref_q == RW'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            anode_q <= ~(4'b0001 << idx_q);
            led_q   <= blank ? 7'b1111111 : seg7(dig_upper[3:0]);
        end
    end

    assign busy    = busy_q;
    assign anode   = anode_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: stimulus queues expected digits per conversion; the monitor checks the
// scanned segments of a blanking and a non-blanking instance after each conversion completes.
module tb_ssd_scan_driver;

    typedef struct {
        string       name;
        logic [15:0] dig;
        logic [3:0]  blank;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [12:0] value;
    logic        update;
    logic        busy0, busy1;
    logic [3:0]  anode0, anode1;
    logic [6:0]  led0, led1;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ssd_scan_driver #(.IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst(rst), .value(value), .update(update),
        .busy(busy0), .anode(anode0), .led_out(led0)
    );

    ssd_scan_driver #(.IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst(rst), .value(value), .update(update),
        .busy(busy1), .anode(anode1), .led_out(led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return (d < 4'd10) ? tbl[d] : 7'b1111111;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input string nm, input logic [15:0] dig, input logic [3:0] blank);
        exp_t e;
        e.name  = nm;
        e.dig   = dig;
        e.blank = blank;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        if (busy0 !== 1'b0) check({nm, "_idle_timeout"}, 32'(busy0), 32'd0);
    endtask

    task automatic convert(input logic [12:0] v, input string nm, input logic [15:0] dig,
                           input logic [3:0] blank);
        int cnt = 0;
        push_exp(nm, dig, blank);
        @(negedge clk);
        value  = v;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 32'(cnt), 32'd14);
        repeat (20) @(negedge clk);
    endtask

    // Monitor: each busy 1->0 marks a finished (or aborted) conversion.
    initial begin : monitor
        exp_t e;
        logic pb;
        bit   fell;
        int   idx;
        pb   = 1'b0;
        fell = 1'b0;
        forever begin
            while (!fell) begin
                @(negedge clk);
                fell = (pb === 1'b1 && busy0 === 1'b0);
                pb   = busy0;
            end
            fell = 1'b0;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: conversion ended with nothing queued");
                continue;
            end
            e = exp_q.pop_front();
            @(negedge clk);
            pb = busy0;
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                fell = (pb === 1'b1 && busy0 === 1'b0);
                pb   = busy0;
                idx  = -1;
                for (int i = 0; i < 4; i++) if (anode0 === ~(4'b0001 << i)) idx = i;
                if (idx < 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL %s_anode: got %b, required one low bit", e.name, anode0);
                end else begin
                    check({e.name, "_lz1"}, 32'(led0),
                          e.blank[idx] ? 32'h7f : 32'(seg_ref(e.dig[idx*4 +: 4])));
                    check({e.name, "_lz0"}, 32'(led1), 32'(seg_ref(e.dig[idx*4 +: 4])));
                end
                if (fell) break;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] an_seq [4];
        an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst    = 1'b1;
        update = 1'b0;
        value  = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_anode", 32'(anode0), 32'hf);
        check("rst_led", 32'(led0), 32'h7f);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("release_led", 32'(led0), 32'b0000001);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            check("scan_order", 32'(anode0), 32'(an_seq[i/4]));
        end

        convert(13'd1234, "v1234", 16'h1234, 4'b0000);
        convert(13'd8191, "v8191", 16'h8191, 4'b0000);
        convert(13'd0,    "v0",    16'h0000, 4'b1110);
        convert(13'd42,   "v42",   16'h0042, 4'b1100);

        // Strobe while busy is dropped; strobe on the first idle cycle is taken.
        push_exp("ign1234", 16'h1234, 4'b0000);
        push_exp("b2b5678", 16'h5678, 4'b0000);
        @(negedge clk);
        value  = 13'd1234;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (2) @(negedge clk);
        value  = 13'd5678;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_idle("ign");
        value  = 13'd5678;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check("b2b_accept", 32'(busy0), 32'd1);
        wait_idle("b2b");
        repeat (20) @(negedge clk);

        // Reset on the fifth conversion cycle aborts; digits read zero.
        push_exp("abort", 16'h0000, 4'b1110);
        @(negedge clk);
        value  = 13'd999;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_anode", 32'(anode0), 32'hf);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        convert(13'd999, "v999", 16'h0999, 4'b1000);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
